rr_encoder16x4: RTL and testbench

- Round-robin priority encoder: the inverse of the register-file select decoder.
- Collapses a 16-bit request vector into one registered 4-bit address plus a matching one-hot grant.
- Used wherever several sources (issue slots, write-back ports) contend for one indexed resource.
- Registered output with a valid/ready handshake, so a stalled consumer holds the grant stable.

---
 rtl/rr_encoder16x4.sv | 92 +++++++++
 tb/tb_rr_encoder16x4.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_encoder16x4.sv
// rtl/rr_encoder16x4.sv - round-robin 16:4 priority encoder with registered valid/ready grant
module rr_encoder16x4 #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [WIDTH-1:0]  req,
   input  logic              flush,
   input  logic              grant_ready,
   output logic              grant_valid,
   output logic [ADDR_W-1:0] grant_addr,
   output logic [WIDTH-1:0]  grant_onehot,
   output logic [ADDR_W:0]   req_count
);

   localparam int CW = ADDR_W + 1;

   logic [ADDR_W-1:0] ptr;
   logic              load;
   logic              accept;
   logic [WIDTH-1:0]  masked;
   logic              found;
   logic [ADDR_W-1:0] sel;
   logic [ADDR_W-1:0] idx;
   logic [CW-1:0]     count_nxt;

   assign load   = !grant_valid || grant_ready;
   assign accept = grant_valid && grant_ready;

   // Search the masked request vector starting at ptr; the granted bit is
   // removed on accept so a requester still dropping its line is not re-granted.
   always_comb begin
      masked = req & ~(accept ? grant_onehot : {WIDTH{1'b0}});
      found  = 1'b0;
      sel    = '0;
      idx    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         idx = ptr + ADDR_W'(i);
         if (!found && masked[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   // Population count of the raw request vector.
   always_comb begin
      count_nxt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         count_nxt = count_nxt + CW'(req[i]);
      end
   end

   // Grant register and round-robin pointer; flush overrides load and accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_valid  <= 1'b0;
         grant_addr   <= '0;
         grant_onehot <= '0;
         ptr          <= '0;
      end else if (flush) begin
         grant_valid  <= 1'b0;
         grant_onehot <= '0;
         ptr          <= '0;
      end else begin
         if (accept) begin
            ptr <= grant_addr + ADDR_W'(1);
         end
         if (load) begin
            if (found) begin
               grant_valid  <= 1'b1;
               grant_addr   <= sel;
               grant_onehot <= WIDTH'(1) << sel;
            end else begin
               grant_valid  <= 1'b0;
               grant_onehot <= '0;
            end
         end
      end
   end

   // Request count is sampled every cycle regardless of stall or flush.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_count <= '0;
      end else begin
         req_count <= count_nxt;
      end
   end

endmodule

// File: tb/tb_rr_encoder16x4.sv
// tb/tb_rr_encoder16x4.sv - self-checking bench for rr_encoder16x4
module tb_rr_encoder16x4;

   logic        clk;
   logic        reset_n;
   logic [15:0] req;
   logic        flush;
   logic        grant_ready;
   logic        grant_valid;
   logic [3:0]  grant_addr;
   logic [15:0] grant_onehot;
   logic [4:0]  req_count;

   int n_checks;
   int n_fail;

   // reference model state
   logic        m_valid;
   logic [3:0]  m_addr;
   logic [3:0]  m_ptr;
   logic [4:0]  m_count;

   rr_encoder16x4 dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req          (req),
      .flush        (flush),
      .grant_ready  (grant_ready),
      .grant_valid  (grant_valid),
      .grant_addr   (grant_addr),
      .grant_onehot (grant_onehot),
      .req_count    (req_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int first_set(input logic [15:0] v, input int p);
      for (int k = 0; k < 16; k++) begin
         if (v[(p + k) % 16]) return (p + k) % 16;
      end
      return -1;
   endfunction

   function automatic logic [15:0] model_onehot();
      return m_valid ? (16'h0001 << m_addr) : 16'h0000;
   endfunction

   // Behavioural model: spec rules applied to whole vectors once per edge.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_valid <= 1'b0;
         m_addr  <= 4'd0;
         m_ptr   <= 4'd0;
         m_count <= 5'd0;
      end else begin
         m_count <= 5'($countones(req));
         if (flush) begin
            m_valid <= 1'b0;
            m_ptr   <= 4'd0;
         end else begin
            if (m_valid && grant_ready) m_ptr <= 4'((int'(m_addr) + 1) % 16);
            if (!m_valid || grant_ready) begin
               if (first_set((m_valid && grant_ready) ? (req & ~(16'h0001 << m_addr)) : req,
                             int'(m_ptr)) >= 0) begin
                  m_valid <= 1'b1;
                  m_addr  <= 4'(first_set((m_valid && grant_ready) ?
                                 (req & ~(16'h0001 << m_addr)) : req, int'(m_ptr)));
               end else begin
                  m_valid <= 1'b0;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] mdl,
                      input logic [31:0] exp);
      chk(name, act, exp);
      chk({name, "_model"}, mdl, exp);
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("cmp_valid",  32'(grant_valid),  32'(m_valid));
      chk("cmp_addr",   32'(grant_addr),   32'(m_addr));
      chk("cmp_onehot", 32'(grant_onehot), 32'(model_onehot()));
      chk("cmp_count",  32'(req_count),    32'(m_count));
      chk("inv_onehot", 32'(grant_onehot), 32'(grant_valid ? (16'h0001 << grant_addr) : 16'h0));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      req   = 16'h0000;
      cyc();
      flush = 1'b0;
   endtask

   logic [3:0] prev;

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      reset_n     = 1'b0;
      req         = 16'h0000;
      flush       = 1'b0;
      grant_ready = 1'b0;
      cyc();
      cyc();
      #2 reset_n = 1'b1;
      cyc();
      lit("rst_valid", 32'(grant_valid), 32'(m_valid), 32'd0);
      lit("rst_addr",  32'(grant_addr),  32'(m_addr),  32'd0);
      lit("rst_count", 32'(req_count),   32'(m_count), 32'd0);

      // single request, drop, next grant follows pointer
      req = 16'h0020; grant_ready = 1'b1;
      cyc();
      lit("single_valid",  32'(grant_valid),  32'(m_valid), 32'd1);
      lit("single_addr",   32'(grant_addr),   32'(m_addr),  32'd5);
      chk("single_onehot", 32'(grant_onehot), 32'h0020);
      req = 16'h0000;
      cyc();
      lit("drop_valid", 32'(grant_valid), 32'(m_valid), 32'd0);
      req = 16'h0041;
      cyc();
      lit("next_addr", 32'(grant_addr), 32'(m_addr), 32'd6);
      req = 16'h0000;
      cyc();

      // wrap / fairness
      do_flush();
      req = 16'h8001; grant_ready = 1'b1;
      prev = 4'd15;
      for (int k = 0; k < 6; k++) begin
         cyc();
         lit("wrap_addr", 32'(grant_addr), 32'(m_addr), (k % 2 == 1) ? 32'd15 : 32'd0);
         chk("wrap_nodup", 32'(grant_addr != prev), 32'd1);
         prev = grant_addr;
      end
      req = 16'h0000;
      cyc();

      // backpressure
      do_flush();
      req = 16'h00F0; grant_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         lit("stall_addr", 32'(grant_addr), 32'(m_addr), 32'd4);
      end
      req = 16'h0100;
      cyc();
      lit("stall_ignore_addr", 32'(grant_addr), 32'(m_addr), 32'd4);
      chk("stall_ignore_onehot", 32'(grant_onehot), 32'h0010);
      grant_ready = 1'b1;
      cyc();
      lit("unstall_addr", 32'(grant_addr), 32'(m_addr), 32'd8);
      req = 16'h0000;
      cyc();

      // full load, bits held
      do_flush();
      req = 16'hFFFF; grant_ready = 1'b1;
      for (int k = 0; k < 17; k++) begin
         cyc();
         lit("full_addr",  32'(grant_addr), 32'(m_addr),  32'(k % 16));
         lit("full_count", 32'(req_count),  32'(m_count), 32'd16);
      end
      req = 16'h0000;
      cyc();

      // flush without and with coincident ready
      for (int r = 0; r < 2; r++) begin
         do_flush();
         req = 16'h0200; grant_ready = 1'b0;
         cyc();
         lit("fl_setup_addr", 32'(grant_addr), 32'(m_addr), 32'd9);
         flush = 1'b1; req = 16'h0600; grant_ready = (r == 1);
         cyc();
         lit("fl_valid",  32'(grant_valid),  32'(m_valid), 32'd0);
         chk("fl_onehot", 32'(grant_onehot), 32'h0000);
         flush = 1'b0; grant_ready = 1'b0;
         cyc();
         lit("fl_after_addr",  32'(grant_addr),  32'(m_addr),  32'd9);
         lit("fl_after_valid", 32'(grant_valid), 32'(m_valid), 32'd1);
      end

      // asynchronous reset mid-stall
      req = 16'h8001;
      #2 reset_n = 1'b0;
      #1;
      lit("arst_valid", 32'(grant_valid), 32'(m_valid), 32'd0);
      chk("arst_onehot", 32'(grant_onehot), 32'h0000);
      lit("arst_count", 32'(req_count), 32'(m_count), 32'd0);
      @(negedge clk);
      #1 reset_n = 1'b1;
      grant_ready = 1'b1;
      cyc();
      lit("arst_first_addr",  32'(grant_addr),  32'(m_addr),  32'd0);
      lit("arst_first_valid", 32'(grant_valid), 32'(m_valid), 32'd1);
      req = 16'h0000;
      cyc();
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
